// File: rtl/brew_sequencer.sv
// rtl/brew_sequencer.sv - tea-brew sequencer: crane lower, pour, raise, plate rotate
// All outputs are registered from next-state values so they line up with the state they describe.
module brew_sequencer #(
    parameter int unsigned STEP_DIV    = 100000,
    parameter int unsigned CRANE_STEPS = 512,
    parameter int unsigned PLATE_STEPS = 128,
    parameter int unsigned POUR_UNIT   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] cup_size,
    output logic       water_pump,
    output logic [3:0] plate_motor_step,
    output logic [3:0] crane_motor_step,
    output logic [2:0] state_code,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned PW = $clog2(CRANE_STEPS + 1);
    localparam int unsigned RW = $clog2(PLATE_STEPS + 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
    localparam logic [PW-1:0] POS_LAST   = PW'(CRANE_STEPS - 1);
    localparam logic [PW-1:0] POS_ONE    = PW'(1);
    localparam logic [RW-1:0] PLATE_LAST = RW'(PLATE_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOWER  = 3'd1,
        S_POUR   = 3'd2,
        S_RAISE  = 3'd3,
        S_ROTATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [RW-1:0] plate_cnt_q, plate_cnt_d;
    logic [31:0]   pour_cnt_q, pour_cnt_d;
    logic [1:0]    cup_q, cup_d;
    logic          abort_flag_q, abort_flag_d;
    logic          aborted_d;
    logic [3:0]    crane_d, plate_d;
    logic          water_pump_q, busy_q, done_q, aborted_q;
    logic [3:0]    crane_q, plate_q;
    logic [2:0]    state_code_q;
    logic          tick;
    logic [31:0]   pour_last;

    function automatic logic [3:0] fwd_coil(input logic [1:0] idx);
        fwd_coil = 4'b1000 >> idx;
    endfunction

    function automatic logic [3:0] rev_coil(input logic [1:0] idx);
        case (idx)
            2'd0:    rev_coil = 4'b1000;
            2'd1:    rev_coil = 4'b0001;
            2'd2:    rev_coil = 4'b0010;
            default: rev_coil = 4'b0100;
        endcase
    endfunction

    assign tick      = (step_cnt_q == STEP_LAST);
    assign pour_last = 32'(cup_q) * POUR_UNIT - 32'd1;

    always_comb begin
        state_d      = state_q;
        step_cnt_d   = tick ? '0 : step_cnt_q + 1'b1;
        phase_d      = tick ? phase_q + 2'd1 : phase_q;
        pos_d        = pos_q;
        plate_cnt_d  = plate_cnt_q;
        pour_cnt_d   = pour_cnt_q + 32'd1;
        cup_d        = cup_q;
        abort_flag_d = abort_flag_q;
        aborted_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_flag_d = 1'b0;
                step_cnt_d   = '0;
                phase_d      = '0;
                pour_cnt_d   = '0;
                plate_cnt_d  = '0;
                if (start && cup_size != 2'd0 && !abort) begin
                    cup_d   = cup_size;
                    state_d = S_LOWER;
                end
            end
            S_LOWER: begin
                // Abort wins over a coincident tick: the crane retraces only completed steps.
                if (abort) begin
                    if (pos_q == '0) begin
                        state_d   = S_IDLE;
                        aborted_d = 1'b1;
                    end else begin
                        abort_flag_d = 1'b1;
                        state_d      = S_RAISE;
                        step_cnt_d   = '0;
                        phase_d      = '0;
                    end
                end else if (tick) begin
                    pos_d = pos_q + 1'b1;
                    if (pos_q == POS_LAST) begin
                        state_d    = S_POUR;
                        pour_cnt_d = '0;
                    end
                end
            end
            S_POUR: begin
                if (abort || pour_cnt_q == pour_last) begin
                    abort_flag_d = abort_flag_q | abort;
                    state_d      = S_RAISE;
                    step_cnt_d   = '0;
                    phase_d      = '0;
                end
            end
            S_RAISE: begin
                abort_flag_d = abort_flag_q | abort;
                if (tick) begin
                    pos_d = pos_q - 1'b1;
                    if (pos_q == POS_ONE) begin
                        if (abort_flag_d) begin
                            state_d   = S_IDLE;
                            aborted_d = 1'b1;
                        end else begin
                            state_d     = S_ROTATE;
                            step_cnt_d  = '0;
                            phase_d     = '0;
                            plate_cnt_d = '0;
                        end
                    end
                end
            end
            S_ROTATE: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    plate_cnt_d = plate_cnt_q + 1'b1;
                    if (plate_cnt_q == PLATE_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        crane_d = 4'b0000;
        plate_d = 4'b0000;
        case (state_d)
            S_LOWER:  crane_d = fwd_coil(phase_d);
            S_RAISE:  crane_d = rev_coil(phase_d);
            S_ROTATE: plate_d = fwd_coil(phase_d);
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_cnt_q   <= '0;
            phase_q      <= '0;
            pos_q        <= '0;
            plate_cnt_q  <= '0;
            pour_cnt_q   <= '0;
            cup_q        <= '0;
            abort_flag_q <= 1'b0;
            water_pump_q <= 1'b0;
            crane_q      <= 4'b0000;
            plate_q      <= 4'b0000;
            state_code_q <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            phase_q      <= phase_d;
            pos_q        <= pos_d;
            plate_cnt_q  <= plate_cnt_d;
            pour_cnt_q   <= pour_cnt_d;
            cup_q        <= cup_d;
            abort_flag_q <= abort_flag_d;
            water_pump_q <= (state_d == S_POUR);
            crane_q      <= crane_d;
            plate_q      <= plate_d;
            state_code_q <= state_d;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
            aborted_q    <= aborted_d;
        end
    end

    assign water_pump       = water_pump_q;
    assign crane_motor_step = crane_q;
    assign plate_motor_step = plate_q;
    assign state_code       = state_code_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign aborted          = aborted_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// tb/tb_brew_sequencer.sv - directed and random checks of brew_sequencer against a duration-based model
module tb_brew_sequencer;

    localparam int SD = 4;
    localparam int CS = 3;
    localparam int PS = 2;
    localparam int PU = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] cup_size = 2'd0;
    logic       water_pump;
    logic [3:0] plate_motor_step;
    logic [3:0] crane_motor_step;
    logic [2:0] state_code;
    logic       busy;
    logic       done;
    logic       aborted;

    brew_sequencer #(
        .STEP_DIV(SD),
        .CRANE_STEPS(CS),
        .PLATE_STEPS(PS),
        .POUR_UNIT(PU)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .cup_size(cup_size),
        .water_pump(water_pump),
        .plate_motor_step(plate_motor_step),
        .crane_motor_step(crane_motor_step),
        .state_code(state_code),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Model: current state, cycles spent in it, its total duration, latched cup, abort flag.
    int ms = 0;
    int mt = 0;
    int mlen = 0;
    int mcup = 0;
    bit mflag = 1'b0;
    bit mpulse = 1'b0;

    logic [3:0] fwd_tab [4];
    logic [3:0] rev_tab [4];
    logic [3:0] st_tr [64];
    logic [3:0] pump_tr [64];
    logic [3:0] crane_tr [64];
    logic [3:0] plate_tr [64];
    logic [3:0] done_tr [64];
    logic [3:0] ab_tr [64];
    int cyc = 0;
    bit saw_done = 1'b0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = 0; mt = 0; mlen = 0; mflag = 1'b0; mpulse = 1'b0;
    endtask

    task automatic enter(input int s, input int len);
        ms = s; mt = 0; mlen = len;
    endtask

    task automatic model_edge(input bit s, input bit a, input logic [1:0] c);
        int p;
        mpulse = 1'b0;
        case (ms)
            0: begin
                mflag = 1'b0;
                if (s && c != 2'd0 && !a) begin
                    mcup = int'(c);
                    enter(1, CS * SD);
                end
            end
            1: begin
                p = mt / SD;
                if (a) begin
                    if (p == 0) begin
                        enter(0, 0); mpulse = 1'b1;
                    end else begin
                        mflag = 1'b1; enter(3, p * SD);
                    end
                end else if (mt + 1 == mlen) enter(2, mcup * PU);
                else mt++;
            end
            2: begin
                if (a) mflag = 1'b1;
                if (a || mt + 1 == mlen) enter(3, CS * SD);
                else mt++;
            end
            3: begin
                if (a) mflag = 1'b1;
                if (mt + 1 == mlen) begin
                    if (mflag) begin
                        enter(0, 0); mpulse = 1'b1;
                    end else enter(4, PS * SD);
                end else mt++;
            end
            4: begin
                if (a) begin
                    enter(0, 0); mpulse = 1'b1;
                end else if (mt + 1 == mlen) enter(5, 1);
                else mt++;
            end
            default: enter(0, 0);
        endcase
    endtask

    function automatic logic [3:0] exp_crane();
        if (ms == 1) return fwd_tab[(mt / SD) % 4];
        if (ms == 3) return rev_tab[(mt / SD) % 4];
        return 4'd0;
    endfunction

    function automatic logic [3:0] exp_plate();
        if (ms == 4) return fwd_tab[(mt / SD) % 4];
        return 4'd0;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".state"}, {1'b0, state_code}, 4'(ms));
        check({tag, ".pump"}, {3'b0, water_pump}, {3'b0, ms == 2});
        check({tag, ".crane"}, crane_motor_step, exp_crane());
        check({tag, ".plate"}, plate_motor_step, exp_plate());
        check({tag, ".busy"}, {3'b0, busy}, {3'b0, ms != 0});
        check({tag, ".done"}, {3'b0, done}, {3'b0, ms == 5});
        check({tag, ".aborted"}, {3'b0, aborted}, {3'b0, mpulse});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".state"}, {1'b0, state_code}, 4'd0);
        check({tag, ".pump"}, {3'b0, water_pump}, 4'd0);
        check({tag, ".crane"}, crane_motor_step, 4'd0);
        check({tag, ".plate"}, plate_motor_step, 4'd0);
        check({tag, ".busy"}, {3'b0, busy}, 4'd0);
        check({tag, ".done"}, {3'b0, done}, 4'd0);
        check({tag, ".aborted"}, {3'b0, aborted}, 4'd0);
    endtask

    task automatic step(input string tag, input bit s, input bit a, input logic [1:0] c);
        start = s; abort = a; cup_size = c;
        @(posedge clk);
        model_edge(s, a, c);
        cyc++;
        #1;
        if (cyc < 64) begin
            st_tr[cyc] = {1'b0, state_code};
            pump_tr[cyc] = {3'b0, water_pump};
            crane_tr[cyc] = crane_motor_step;
            plate_tr[cyc] = plate_motor_step;
            done_tr[cyc] = {3'b0, done};
            ab_tr[cyc] = {3'b0, aborted};
        end
        if (done) saw_done = 1'b1;
        compare_all(tag);
    endtask

    task automatic begin_scenario();
        cyc = 0; saw_done = 1'b0;
    endtask

    initial begin
        fwd_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        rev_tab = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};

        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        model_reset();
        #10 rst = 1'b0;

        // Normal brew, accepted on first edge after reset; late cup change and second start ignored.
        begin_scenario();
        step("brew", 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 44; k++) step("brew", k == 5, 1'b0, (k >= 3) ? 2'd3 : 2'd1);
        check("brew.c1", st_tr[1], 4'd1);
        check("brew.c12", st_tr[12], 4'd1);
        check("brew.c13", st_tr[13], 4'd2);
        check("brew.pump13", pump_tr[13], 4'd1);
        check("brew.pump22", pump_tr[22], 4'd1);
        check("brew.c23", st_tr[23], 4'd3);
        check("brew.pump23", pump_tr[23], 4'd0);
        check("brew.c34", st_tr[34], 4'd3);
        check("brew.c35", st_tr[35], 4'd4);
        check("brew.c42", st_tr[42], 4'd4);
        check("brew.c43", st_tr[43], 4'd5);
        check("brew.done43", done_tr[43], 4'd1);
        check("brew.c44", st_tr[44], 4'd0);
        check("coil.l1", crane_tr[1], 4'b1000);
        check("coil.l4", crane_tr[4], 4'b1000);
        check("coil.l5", crane_tr[5], 4'b0100);
        check("coil.l9", crane_tr[9], 4'b0010);
        check("coil.l12", crane_tr[12], 4'b0010);
        check("coil.r23", crane_tr[23], 4'b1000);
        check("coil.r27", crane_tr[27], 4'b0001);
        check("coil.r31", crane_tr[31], 4'b0010);
        check("coil.p_l5", plate_tr[5], 4'b0000);
        check("coil.p_r27", plate_tr[27], 4'b0000);
        check("coil.p35", plate_tr[35], 4'b1000);
        check("coil.p39", plate_tr[39], 4'b0100);

        // Abort during POUR.
        begin_scenario();
        step("abpour", 1'b1, 1'b0, 2'd3);
        for (int k = 1; k <= 30; k++) step("abpour", 1'b0, k == 15, 2'd3);
        check("abpour.pump15", pump_tr[15], 4'd1);
        check("abpour.pump16", pump_tr[16], 4'd0);
        check("abpour.c16", st_tr[16], 4'd3);
        check("abpour.c27", st_tr[27], 4'd3);
        check("abpour.c28", st_tr[28], 4'd0);
        check("abpour.ab28", ab_tr[28], 4'd1);
        check("abpour.ab29", ab_tr[29], 4'd0);
        check("abpour.nodone", {3'b0, saw_done}, 4'd0);

        // Abort in LOWER after one step.
        begin_scenario();
        step("ablow", 1'b1, 1'b0, 2'd2);
        for (int k = 1; k <= 12; k++) step("ablow", 1'b0, k == 6, 2'd2);
        check("ablow.c7", st_tr[7], 4'd3);
        check("ablow.c10", st_tr[10], 4'd3);
        check("ablow.c11", st_tr[11], 4'd0);
        check("ablow.ab11", ab_tr[11], 4'd1);

        // Abort in LOWER at position 0.
        begin_scenario();
        step("ablow0", 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 4; k++) step("ablow0", 1'b0, k == 2, 2'd1);
        check("ablow0.c3", st_tr[3], 4'd0);
        check("ablow0.ab3", ab_tr[3], 4'd1);

        // Ignored starts: cup_size 0, and start with abort.
        begin_scenario();
        step("ign", 1'b1, 1'b0, 2'd0);
        step("ign", 1'b1, 1'b1, 2'd2);
        check("ign.c2", st_tr[2], 4'd0);

        // Abort in ROTATE.
        begin_scenario();
        step("abrot", 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 40; k++) step("abrot", 1'b0, k == 37, 2'd1);
        check("abrot.c37", st_tr[37], 4'd4);
        check("abrot.c38", st_tr[38], 4'd0);
        check("abrot.p38", plate_tr[38], 4'd0);
        check("abrot.ab38", ab_tr[38], 4'd1);

        // Asynchronous reset mid-POUR, then a full brew.
        begin_scenario();
        step("rstpour", 1'b1, 1'b0, 2'd2);
        for (int k = 1; k <= 17; k++) step("rstpour", 1'b0, 1'b0, 2'd2);
        check("rstpour.pump18", pump_tr[18], 4'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rstpour.async");
        model_reset();
        #1 rst = 1'b0;
        begin_scenario();
        step("after", 1'b1, 1'b0, 2'd1);
        for (int k = 1; k <= 44; k++) step("after", 1'b0, 1'b0, 2'd1);
        check("after.c13", st_tr[13], 4'd2);
        check("after.c43", st_tr[43], 4'd5);
        check("after.c44", st_tr[44], 4'd0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++)
            step("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
